sub_bytes_seq: RTL and testbench

Multi-cycle AES SubBytes stage that sits directly upstream of the ShiftRows stage in the cipher round datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through replicated S-box instances. It then presents the substituted state to the ShiftRows input over a valid/ready handshake. The design trades latency for S-box area.

---
 rtl/sub_bytes_seq.sv | 157 +++++++++++++++
 tb/tb_sub_bytes_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
// AES SubBytes stage: BYTES_PER_CYCLE S-box lanes over 16/BYTES_PER_CYCLE beats; SUB_BYTES_INV_EN adds inverse mode.
// Latency: out_valid rises 16/BYTES_PER_CYCLE cycles after accept; initiation interval is that plus 2.
// Backpressure: result holds in DONE until out_ready; in_ready is high only in IDLE.
module sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
`ifdef SUB_BYTES_INV_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int BEATS = 16 / BYTES_PER_CYCLE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_cfg
            $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Byte b of the table lives at bits [2047-8b -: 8].
    localparam logic [2047:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX_FWD[2047 - 8*int'(b) -: 8];
    endfunction

`ifdef SUB_BYTES_INV_EN
    localparam logic [2047:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return SBOX_INV[2047 - 8*int'(b) -: 8];
    endfunction

    logic inv_q;
`endif

    function automatic int byte_hi(input int k);
        return 127 - 8*k;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [127:0]   state_q;
    logic [CW-1:0]  cnt;
    logic [127:0]   sub_state;

    // One S-box lane per byte of the current beat; remaining bytes pass through.
    always_comb begin
        sub_state = state_q;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
`ifdef SUB_BYTES_INV_EN
            sub_state[byte_hi(int'(cnt)*BYTES_PER_CYCLE + j) -: 8] =
                inv_q ? sbox_inv(state_q[byte_hi(int'(cnt)*BYTES_PER_CYCLE + j) -: 8])
                      : sbox_fwd(state_q[byte_hi(int'(cnt)*BYTES_PER_CYCLE + j) -: 8]);
`else
            sub_state[byte_hi(int'(cnt)*BYTES_PER_CYCLE + j) -: 8] =
                sbox_fwd(state_q[byte_hi(int'(cnt)*BYTES_PER_CYCLE + j) -: 8]);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            state_q <= '0;
            cnt     <= '0;
`ifdef SUB_BYTES_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= data_in;
                        cnt     <= '0;
`ifdef SUB_BYTES_INV_EN
                        inv_q   <= inv;
`endif
                        state   <= SUB;
                    end
                end
                SUB: begin
                    state_q <= sub_state;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == SUB) || (state == DONE);
    assign data_out  = state_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (4, 1, 16 bytes/cycle) against a transaction-level model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_seq;

    localparam int NI = 3;

    function automatic int bpc_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 16;
    endfunction

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic         busy      [NI];
    logic [127:0] data_in   [NI];
    logic [127:0] data_out  [NI];
`ifdef SUB_BYTES_INV_EN
    logic         inv       [NI];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_bytes_seq #(.BYTES_PER_CYCLE(bpc_of(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .data_in   (data_in[g]),
`ifdef SUB_BYTES_INV_EN
            .inv       (inv[g]),
`endif
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .data_out  (data_out[g]),
            .busy      (busy[g])
        );
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference S-box built from field arithmetic, not from a transcribed table.
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] subst(input logic [127:0] d, input logic use_inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = d[127 - 8*k -: 8];
            r[127 - 8*k -: 8] = use_inv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic inv_of(input int i);
`ifdef SUB_BYTES_INV_EN
        return inv[i];
`else
        return (i < 0);
`endif
    endfunction

    // Transaction model: 0 = free, 1 = working (cycles left), 2 = result presented.
    int           m_phase [NI];
    int           m_left  [NI];
    logic [127:0] m_res   [NI];
    logic [127:0] m_shown [NI];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_phase[i] <= 0;
                m_left[i]  <= 0;
                m_res[i]   <= '0;
                m_shown[i] <= '0;
            end else begin
                case (m_phase[i])
                    0: if (in_valid[i]) begin
                        m_res[i]   <= subst(data_in[i], inv_of(i));
                        m_left[i]  <= 16 / bpc_of(i);
                        m_phase[i] <= 1;
                    end
                    1: begin
                        m_left[i] <= m_left[i] - 1;
                        if (m_left[i] == 1) begin
                            m_phase[i] <= 2;
                            m_shown[i] <= m_res[i];
                        end
                    end
                    default: if (out_ready[i]) m_phase[i] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk1($sformatf("u%0d_in_ready", i), in_ready[i], m_phase[i] == 0);
                chk1($sformatf("u%0d_busy", i), busy[i], m_phase[i] != 0);
                chk1($sformatf("u%0d_out_valid", i), out_valid[i], m_phase[i] == 2);
                if (m_phase[i] == 2)
                    chkd($sformatf("u%0d_data_out", i), data_out[i], m_res[i]);
                else if (m_phase[i] == 0)
                    chkd($sformatf("u%0d_data_idle", i), data_out[i], m_shown[i]);
            end
        end
    end

    task automatic send(input int i, input logic [127:0] d, input logic iv, output int t0);
        bit ok;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b1;
        data_in[i]  = d;
`ifdef SUB_BYTES_INV_EN
        inv[i]      = iv;
`endif
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (in_ready[i]) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL u%0d_accept_timeout: in_ready never seen", i);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
`ifdef SUB_BYTES_INV_EN
        inv[i]      = ~iv;
`else
        if (iv) data_in[i] = ~d;
`endif
        t0 = cyc;
    endtask

    task automatic wait_out(input int i, input int t0, input int exp_lat, input string nm, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (out_valid[i]) ok = 1'b1;
        end
        if (ok) chki({nm, "_latency"}, cyc - t0, exp_lat);
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid never seen", nm);
        end
    endtask

    task automatic recv(input int i, input int t0, input int exp_lat, input logic [127:0] exp, input string nm);
        bit ok;
        wait_out(i, t0, exp_lat, nm, ok);
        if (ok) begin
            chkd({nm, "_data"}, data_out[i], exp);
            out_ready[i] = 1'b1;
            @(posedge clk);
            #1;
            out_ready[i] = 1'b0;
        end
    endtask

    localparam logic [127:0] P    = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] PX   = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
    localparam logic [127:0] PINV = 128'h52096ad5_3036a538_bf40a39e_81f3d7fb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  t0;
        bit  ok;
        logic [7:0] p, s;

        for (int a = 0; a < 256; a++) begin
            p = 8'h01;
            for (int e = 0; e < 254; e++) p = gmul(p, 8'(a));
            s = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
            fwd_tab[a] = s;
            inv_tab[s] = 8'(a);
        end
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            data_in[i]   = '0;
`ifdef SUB_BYTES_INV_EN
            inv[i]       = 1'b0;
`endif
        end

        // Model pins against hand-computed FIPS-197 values.
        chkd("pin_sbox_00", {120'h0, fwd_tab[8'h00]}, 128'h63);
        chkd("pin_sbox_ff", {120'h0, fwd_tab[8'hff]}, 128'h16);
        chkd("pin_sbox_53", {120'h0, fwd_tab[8'h53]}, 128'hed);
        chkd("pin_inv_63", {120'h0, inv_tab[8'h63]}, 128'h00);
        chkd("pin_inv_00", {120'h0, inv_tab[8'h00]}, 128'h52);
        chkd("pin_subst_P", subst(P, 1'b0), PX);
        chkd("pin_subst_Pinv", subst(P, 1'b1), PINV);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("rst_in_ready", in_ready[0], 1'b1);
        chk1("rst_out_valid", out_valid[0], 1'b0);
        chk1("rst_busy", busy[0], 1'b0);
        chkd("rst_data_out", data_out[0], 128'h0);

        send(0, 128'h0, 1'b0, t0);
        recv(0, t0, 4, {16{8'h63}}, "zero_blk");
        send(0, P, 1'b0, t0);
        recv(0, t0, 4, PX, "seq_bpc4");
        send(1, P, 1'b0, t0);
        recv(1, t0, 16, PX, "seq_bpc1");
        send(2, P, 1'b0, t0);
        recv(2, t0, 1, PX, "seq_bpc16");

        // Backpressure: a second block is offered while the first sits in DONE.
        send(0, {16{8'h53}}, 1'b0, t0);
        wait_out(0, t0, 4, "bp_first", ok);
        in_valid[0] = 1'b1;
        data_in[0]  = P;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk1("bp_out_valid", out_valid[0], 1'b1);
            chk1("bp_in_ready", in_ready[0], 1'b0);
            chkd("bp_data", data_out[0], {16{8'hed}});
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        @(negedge clk);
        chk1("bp_in_ready_after", in_ready[0], 1'b1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        t0 = cyc;
        recv(0, t0, 4, PX, "bp_second");

        // Reset in the middle of SUB.
        send(0, P, 1'b0, t0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk1("mid_busy_before", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_in_ready", in_ready[0], 1'b1);
        chk1("mid_rst_out_valid", out_valid[0], 1'b0);
        chk1("mid_rst_busy", busy[0], 1'b0);
        chkd("mid_rst_data", data_out[0], 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(0, {16{8'hff}}, 1'b0, t0);
        recv(0, t0, 4, {16{8'h16}}, "after_rst_ff");

`ifdef SUB_BYTES_INV_EN
        send(0, {16{8'h63}}, 1'b1, t0);
        recv(0, t0, 4, {16{8'h00}}, "inv_63");
        send(0, {16{8'h00}}, 1'b1, t0);
        recv(0, t0, 4, {16{8'h52}}, "inv_00");
        for (int j = 0; j < 4; j++) begin
            send(0, P, (j % 2) == 1, t0);
            recv(0, t0, 4, ((j % 2) == 1) ? PINV : PX, $sformatf("inv_toggle%0d", j));
        end
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
